pipe_stage_skid: RTL

- Parametrised pipeline stage register that succeeds the fixed-field stage registers between the ID/EX/MEM/WB stages.
- Carries one opaque data word and one control word per instruction, with a valid/ready handshake.
- A 2-entry skid buffer gives full throughput while in_ready stays a registered signal.
- Supports flush (bubble insertion); downstream stages always see bubble control whenever the slot is empty.

---
 rtl/pipe_pkg.sv | 48 ++++
 rtl/pipe_stage_skid_slot.sv | 37 +++
 rtl/pipe_stage_skid.sv | 87 ++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: control word layout, bubble value, opcodes.
// Imported by every pipeline stage register.
package pipe_pkg;

  localparam int CTRL_W = 24;

  localparam int ALUOP_LSB    = 0;
  localparam int ALUOP_W      = 4;
  localparam int ALUSRC_BIT   = 4;
  localparam int MEMWRITE_BIT = 5;
  localparam int MEMREAD_BIT  = 6;
  localparam int REGWRITE_BIT = 7;
  localparam int MEMTOREG_LSB = 8;
  localparam int MEMTOREG_W   = 2;
  localparam int J_BIT        = 10;
  localparam int BRA_BIT      = 11;
  localparam int BNE_BIT      = 12;
  localparam int STDATA_LSB   = 13;
  localparam int STDATA_W     = 3;
  localparam int LDDATA_LSB   = 16;
  localparam int LDDATA_W     = 4;
  localparam int WMASK_LSB    = 20;
  localparam int WMASK_W      = 4;

  // All-zero control is a NOP: no register or memory write.
  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = '0;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLT = 4'd5;

endpackage

// File: rtl/pipe_stage_skid_slot.sv
// One valid+data+ctrl register entry with load, kill and flush.
// Flush clears valid and ctrl but leaves data untouched.
module pipe_slot #(
  parameter int DW = 192,
  parameter int CW = 24,
  parameter logic [CW-1:0] BUB = '0
) (
  input  logic          clk,
  input  logic          nrst,
  input  logic          flush,
  input  logic          load,
  input  logic          kill,
  input  logic [DW-1:0] d_data,
  input  logic [CW-1:0] d_ctrl,
  output logic          valid,
  output logic [DW-1:0] data,
  output logic [CW-1:0] ctrl
);

  always_ff @(posedge clk) begin
    if (!nrst) begin
      valid <= 1'b0;
      data  <= '0;
      ctrl  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      ctrl  <= BUB;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d_data;
      ctrl  <= d_ctrl;
    end else if (kill) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 2-entry skid buffer and flush.
// in_ready is the inverted skid valid flop, so it is fully registered.
module pipe_stage_skid #(
  parameter int DATA_W = 192,
  parameter int CTRL_W = pipe_pkg::CTRL_W,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = pipe_pkg::BUBBLE_CTRL
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              main_valid, skid_valid;
  logic [DATA_W-1:0] main_data, skid_data;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic              in_fire, out_fire;
  logic              main_load, main_kill;
  logic              skid_load, skid_kill;
  logic [DATA_W-1:0] main_d_data;
  logic [CTRL_W-1:0] main_d_ctrl;

  assign in_ready = !skid_valid;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  assign main_load = (!main_valid & in_fire)
                   | (!skid_valid & in_fire & out_fire)
                   | (skid_valid & out_fire);
  assign main_kill = main_valid & !skid_valid
                   & !in_fire & out_fire;
  assign skid_load = main_valid & !skid_valid
                   & in_fire & !out_fire;
  assign skid_kill = skid_valid & out_fire;

  // Draining FULL promotes the skid entry, otherwise take the input.
  assign main_d_data = skid_valid ? skid_data : in_data;
  assign main_d_ctrl = skid_valid ? skid_ctrl : in_ctrl;

  pipe_slot #(
    .DW (DATA_W),
    .CW (CTRL_W),
    .BUB(BUBBLE_CTRL)
  ) u_main (
    .clk   (clk),
    .nrst  (nrst),
    .flush (flush),
    .load  (main_load),
    .kill  (main_kill),
    .d_data(main_d_data),
    .d_ctrl(main_d_ctrl),
    .valid (main_valid),
    .data  (main_data),
    .ctrl  (main_ctrl)
  );

  pipe_slot #(
    .DW (DATA_W),
    .CW (CTRL_W),
    .BUB(BUBBLE_CTRL)
  ) u_skid (
    .clk   (clk),
    .nrst  (nrst),
    .flush (flush),
    .load  (skid_load),
    .kill  (skid_kill),
    .d_data(in_data),
    .d_ctrl(in_ctrl),
    .valid (skid_valid),
    .data  (skid_data),
    .ctrl  (skid_ctrl)
  );

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : BUBBLE_CTRL;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule
